// File: rtl/crc_tx_scheduler.sv
// Packet scheduler feeding the crc block: arbitrates hs/tok/dat requests, then
// serializes the granted sync+PID[+fields] bits LSB-first as pkt_in/s_in/endr.
module crc_tx_scheduler #(
    parameter logic [9:0] TIMEOUT = 10'd511
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs_req,
    input  logic [15:0] hs_bits,
    input  logic        tok_req,
    input  logic [26:0] tok_bits,
    input  logic        dat_req,
    input  logic [79:0] dat_bits,
    input  logic        endb,
    output logic        gnt_hs,
    output logic        gnt_tok,
    output logic        gnt_dat,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic [1:0]  pkt_in,
    output logic        s_in,
    output logic        endr
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_END   = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam logic [1:0] CODE_TOK = 2'b01;
    localparam logic [1:0] CODE_DAT = 2'b11;
    localparam logic [1:0] CODE_HS  = 2'b10;

    state_t      state_r;
    state_t      state_s;
    logic [79:0] shreg_r;
    logic [6:0]  len_r;
    logic [6:0]  bitcnt_r;
    logic [9:0]  to_cnt_r;
    logic [1:0]  code_r;
    logic        gnt_hs_r;
    logic        gnt_tok_r;
    logic        gnt_dat_r;
    logic        err_r;
    logic        busy_r;
    logic [1:0]  pkt_in_r;
    logic        s_in_r;
    logic        endr_r;
    logic        any_req_s;
    logic        last_bit_s;
    logic        expire_s;

    assign any_req_s  = hs_req | tok_req | dat_req;
    assign last_bit_s = (bitcnt_r == (len_r - 7'd1));
    assign expire_s   = (to_cnt_r == (TIMEOUT - 10'd1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; endb in DRAIN takes precedence over the timeout
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) state_s = ST_START;
                else           state_s = ST_IDLE;
            end
            ST_START: state_s = ST_SHIFT;
            ST_SHIFT: begin
                if (last_bit_s) state_s = ST_END;
                else            state_s = ST_SHIFT;
            end
            ST_END: state_s = ST_DRAIN;
            ST_DRAIN: begin
                if (endb || expire_s) state_s = ST_IDLE;
                else                  state_s = ST_DRAIN;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs; each output shows the action of the previous state
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r   <= 80'd0;
            len_r     <= 7'd0;
            bitcnt_r  <= 7'd0;
            to_cnt_r  <= 10'd0;
            code_r    <= 2'b00;
            gnt_hs_r  <= 1'b0;
            gnt_tok_r <= 1'b0;
            gnt_dat_r <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
            pkt_in_r  <= 2'b00;
            s_in_r    <= 1'b0;
            endr_r    <= 1'b0;
        end else begin
            gnt_hs_r  <= 1'b0;
            gnt_tok_r <= 1'b0;
            gnt_dat_r <= 1'b0;
            err_r     <= 1'b0;
            pkt_in_r  <= 2'b00;
            s_in_r    <= 1'b0;
            endr_r    <= 1'b0;
            busy_r    <= (state_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (hs_req) begin
                        gnt_hs_r <= 1'b1;
                        shreg_r  <= {64'd0, hs_bits};
                        len_r    <= 7'd16;
                        code_r   <= CODE_HS;
                    end else if (tok_req) begin
                        gnt_tok_r <= 1'b1;
                        shreg_r   <= {53'd0, tok_bits};
                        len_r     <= 7'd27;
                        code_r    <= CODE_TOK;
                    end else if (dat_req) begin
                        gnt_dat_r <= 1'b1;
                        shreg_r   <= dat_bits;
                        len_r     <= 7'd80;
                        code_r    <= CODE_DAT;
                    end
                end
                ST_START: begin
                    pkt_in_r <= code_r;
                    bitcnt_r <= 7'd0;
                end
                ST_SHIFT: begin
                    s_in_r   <= shreg_r[0];
                    shreg_r  <= {1'b0, shreg_r[79:1]};
                    bitcnt_r <= bitcnt_r + 7'd1;
                end
                ST_END: begin
                    endr_r   <= 1'b1;
                    to_cnt_r <= 10'd0;
                end
                ST_DRAIN: begin
                    to_cnt_r <= to_cnt_r + 10'd1;
                    if (!endb && expire_s) err_r <= 1'b1;
                end
                default: begin
                    bitcnt_r <= 7'd0;
                end
            endcase
        end
    end

    // done must coincide with the endb pulse itself, so it is decoded from the live state
    assign done    = (state_r == ST_DRAIN) && endb;
    assign gnt_hs  = gnt_hs_r;
    assign gnt_tok = gnt_tok_r;
    assign gnt_dat = gnt_dat_r;
    assign err     = err_r;
    assign busy    = busy_r;
    assign pkt_in  = pkt_in_r;
    assign s_in    = s_in_r;
    assign endr    = endr_r;

endmodule

// File: tb/tb_crc_tx_scheduler.sv
// Bench for crc_tx_scheduler: a packet-timeline model (cycles since grant) checks
// every output each cycle; directed scenarios add hand-computed timing/bit checks.
module tb_crc_tx_scheduler;

    localparam int TO = 511;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hs_req = 1'b0;
    logic [15:0] hs_bits = 16'd0;
    logic        tok_req = 1'b0;
    logic [26:0] tok_bits = 27'd0;
    logic        dat_req = 1'b0;
    logic [79:0] dat_bits = 80'd0;
    logic        endb = 1'b0;
    logic        gnt_hs, gnt_tok, gnt_dat, done, err, busy, s_in, endr;
    logic [1:0]  pkt_in;

    crc_tx_scheduler dut (
        .clk(clk), .rst(rst),
        .hs_req(hs_req), .hs_bits(hs_bits),
        .tok_req(tok_req), .tok_bits(tok_bits),
        .dat_req(dat_req), .dat_bits(dat_bits),
        .endb(endb),
        .gnt_hs(gnt_hs), .gnt_tok(gnt_tok), .gnt_dat(gnt_dat),
        .done(done), .err(err), .busy(busy),
        .pkt_in(pkt_in), .s_in(s_in), .endr(endr)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int mis = 0;
    int cyc = 0;
    bit check_en = 1'b0;

    // packet-timeline model
    bit          m_idle = 1'b1;
    bit          m_errflag = 1'b0;
    int          m_t = 0;
    int          m_len = 0;
    logic [79:0] m_bits = 80'd0;
    logic [1:0]  m_code = 2'b00;
    logic [2:0]  m_which = 3'b000;

    // observation records
    int          gnt_cnt = 0, endr_cnt = 0, done_cnt = 0, err_cnt = 0;
    int          last_gnt_cyc = 0, last_pkt_cyc = 0, last_endr_cyc = 0;
    int          last_done_cyc = 0, last_err_cyc = 0;
    logic [2:0]  last_gnt_which = 3'b000;
    logic [79:0] cap = 80'd0;
    int          capn = 0;
    bit          capping = 1'b0;
    int          idle_run = 0, last_gap = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_and_check();
        logic [9:0] e;
        logic [9:0] a;
        logic [2:0] eg;
        logic [1:0] ep;
        logic es, eendr, edone, eerr, ebusy;
        eg = 3'b000; ep = 2'b00; es = 1'b0; eendr = 1'b0;
        edone = 1'b0; eerr = 1'b0; ebusy = 1'b0;
        if (m_idle) begin
            eerr = m_errflag;
        end else begin
            ebusy = 1'b1;
            if (m_t == 0) eg = m_which;
            if (m_t == 1) ep = m_code;
            if (m_t >= 2 && m_t <= m_len + 1) es = m_bits[m_t - 2];
            if (m_t == m_len + 2) eendr = 1'b1;
            if (m_t >= m_len + 2 && endb) edone = 1'b1;
        end
        e = {eg, ep, es, eendr, edone, eerr, ebusy};
        a = {gnt_hs, gnt_tok, gnt_dat, pkt_in, s_in, endr, done, err, busy};
        if (check_en) begin
            chk("cycle outputs {gnt3,pkt2,s_in,endr,done,err,busy}", 80'(a), 80'(e));
            if (gnt_hs || gnt_tok || gnt_dat) begin
                gnt_cnt++; last_gnt_cyc = cyc; last_gnt_which = {gnt_hs, gnt_tok, gnt_dat};
            end
            if (pkt_in != 2'b00) begin
                last_pkt_cyc = cyc; cap = 80'd0; capn = 0; capping = 1'b1;
            end else if (endr) begin
                endr_cnt++; last_endr_cyc = cyc; capping = 1'b0;
            end else if (capping && capn < 80) begin
                cap[capn] = s_in; capn++;
            end
            if (done) begin done_cnt++; last_done_cyc = cyc; end
            if (err) begin err_cnt++; last_err_cyc = cyc; end
            if (!busy) idle_run++;
            else begin
                if (idle_run > 0) last_gap = idle_run;
                idle_run = 0;
            end
        end
        if (rst) begin
            m_idle = 1'b1; m_errflag = 1'b0;
        end else if (m_idle) begin
            m_errflag = 1'b0;
            if (hs_req || tok_req || dat_req) begin
                m_idle = 1'b0; m_t = 0;
                if (hs_req) begin
                    m_which = 3'b100; m_len = 16; m_bits = 80'(hs_bits); m_code = 2'b10;
                end else if (tok_req) begin
                    m_which = 3'b010; m_len = 27; m_bits = 80'(tok_bits); m_code = 2'b01;
                end else begin
                    m_which = 3'b001; m_len = 80; m_bits = dat_bits; m_code = 2'b11;
                end
            end
        end else if (edone) begin
            m_idle = 1'b1; m_errflag = 1'b0;
        end else if (m_t - (m_len + 2) == TO - 1) begin
            m_idle = 1'b1; m_errflag = 1'b1;
        end else begin
            m_t++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_and_check();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_gnt(output int g);
        int pre = gnt_cnt;
        int n = 0;
        while (gnt_cnt == pre && n < 400) begin tick(); n++; end
        if (gnt_cnt == pre) begin
            vec++; mis++;
            $display("FAIL grant wait @cycle %0d: got no grant expected one within 400 cycles", cyc);
        end
        g = last_gnt_cyc;
    endtask

    task automatic wait_endr();
        int pre = endr_cnt;
        int n = 0;
        while (endr_cnt == pre && n < 200) begin tick(); n++; end
        if (endr_cnt == pre) begin
            vec++; mis++;
            $display("FAIL endr wait @cycle %0d: got no endr expected one within 200 cycles", cyc);
        end
    endtask

    // which: 0=hs 1=tok 2=dat; endb is pulsed at grant cycle + off
    task automatic send(input int which, input int off, output int g);
        logic [2:0] w;
        if (which == 0) begin hs_req = 1'b1; w = 3'b100; end
        else if (which == 1) begin tok_req = 1'b1; w = 3'b010; end
        else begin dat_req = 1'b1; w = 3'b001; end
        wait_gnt(g);
        chk("grant type", 80'(last_gnt_which), 80'(w));
        if (which == 0) hs_req = 1'b0;
        else if (which == 1) tok_req = 1'b0;
        else dat_req = 1'b0;
        wait_endr();
        while (cyc < g + off) tick();
        endb = 1'b1; tick(); endb = 1'b0; tick();
    endtask

    initial begin
        int g, g1, g2, d1, dc, ec, d;
        // reset
        rst = 1'b1; tick(); tick();
        rst = 1'b0; check_en = 1'b1;
        chk("post-reset outputs", 80'({gnt_hs, gnt_tok, gnt_dat, pkt_in, s_in, endr, done, err, busy}), 80'd0);
        tick(); tick();

        // handshake packet, endb 40 cycles after grant
        hs_bits = 16'hD280;
        send(0, 40, g);
        chk("hs pkt_in offset", 80'(last_pkt_cyc - g), 80'd1);
        chk("hs endr offset", 80'(last_endr_cyc - g), 80'd18);
        chk("hs done offset", 80'(last_done_cyc - g), 80'd40);
        chk("hs bit count", 80'(capn), 80'd16);
        chk("hs serial bits", cap, 80'hD280);
        tick(); tick();

        // token and data requested together: token first
        tok_bits = 27'h2D3C21D;
        dat_bits = 80'h1EC3_0123_4567_89AB_CDEF;
        tok_req = 1'b1; dat_req = 1'b1;
        send(1, 35, g1);
        d1 = last_done_cyc;
        chk("tok serial bits", cap, 80'h2D3C21D);
        send(2, 90, g2);
        chk("dat granted after tok done", 80'(g2 > d1), 80'd1);
        chk("tok-dat idle gap", 80'(last_gap), 80'd1);
        chk("dat endr offset", 80'(last_endr_cyc - g2), 80'd82);
        chk("dat bit count", 80'(capn), 80'd80);
        chk("dat serial bits", cap, 80'h1EC3_0123_4567_89AB_CDEF);
        tick(); tick(); tick();

        // all three together: hs, tok, dat
        hs_bits = 16'h4B3C; tok_bits = 27'h0A5F00F; dat_bits = 80'hFFFF_0000_A5A5_5A5A_1234;
        hs_req = 1'b1; tok_req = 1'b1; dat_req = 1'b1;
        send(0, 25, g);
        send(1, 33, g);
        chk("hs-tok idle gap", 80'(last_gap), 80'd1);
        send(2, 86, g);
        chk("tok-dat idle gap (3 req)", 80'(last_gap), 80'd1);
        tick(); tick();

        // DRAIN timeout: no endb after token
        dc = done_cnt; ec = err_cnt;
        tok_req = 1'b1;
        wait_gnt(g);
        tok_req = 1'b0;
        wait_endr();
        d = last_endr_cyc;
        begin
            int n = 0;
            while (err_cnt == ec && n < 700) begin tick(); n++; end
        end
        chk("err count after timeout", 80'(err_cnt - ec), 80'd1);
        chk("err offset from DRAIN entry", 80'(last_err_cyc - d), 80'd511);
        chk("no done on timeout", 80'(done_cnt - dc), 80'd0);
        dat_bits = 80'h0F0F_1234_5678_9ABC_DEF0;
        send(2, 84, g);
        chk("dat after timeout bits", cap, 80'h0F0F_1234_5678_9ABC_DEF0);
        tick(); tick();

        // reset in the middle of data SHIFT
        dc = done_cnt; ec = err_cnt;
        dat_bits = 80'hC001_D00D_0000_FFFF_8421;
        dat_req = 1'b1;
        wait_gnt(g);
        dat_req = 1'b0;
        repeat (20) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid-shift reset outputs", 80'({gnt_hs, gnt_tok, gnt_dat, pkt_in, s_in, endr, done, err, busy}), 80'd0);
        repeat (5) tick();
        chk("no done/err after reset", 80'({done_cnt - dc, err_cnt - ec}), 80'd0);
        send(2, 85, g);
        chk("re-sent dat bit count", 80'(capn), 80'd80);
        chk("re-sent dat bits", cap, 80'hC001_D00D_0000_FFFF_8421);
        tick(); tick();

        // stray endb during SHIFT ignored
        dc = done_cnt;
        hs_bits = 16'h1E69;
        hs_req = 1'b1;
        wait_gnt(g);
        hs_req = 1'b0;
        repeat (3) tick();
        endb = 1'b1; tick(); endb = 1'b0;
        wait_endr();
        while (cyc < g + 30) tick();
        endb = 1'b1; tick(); endb = 1'b0; tick();
        chk("single done after stray endb", 80'(done_cnt - dc), 80'd1);
        chk("done on drain endb", 80'(last_done_cyc - g), 80'd30);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
